// File: rtl/dispatch_scheduler.sv
// rtl/dispatch_scheduler.sv - in-order dispatch FIFO with per-FU credit gating; optional counters under DISPATCH_STATS_EN
module dispatch_scheduler #(
  parameter int DEPTH    = 4,
  parameter int RS_DEPTH = 4,
  parameter int CW       = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [31:0] inst_i,
  input  logic        alu_i,
  input  logic        lsu_i,
  input  logic        mul_i,
  input  logic        br_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  output logic        alu_valid_o,
  output logic        lsu_valid_o,
  output logic        mul_valid_o,
  output logic        br_valid_o,
  output logic [31:0] disp_inst_o,
  output logic [4:0]  disp_rs1_o,
  output logic [4:0]  disp_rs2_o,
  output logic [4:0]  disp_rd_o,
  input  logic        alu_free_i,
  input  logic        lsu_free_i,
  input  logic        mul_free_i,
  input  logic        br_free_i,
  output logic        illegal_o,
  output logic        credit_err_o
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] disp_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Bit order of every per-FU vector: 0=ALU, 1=LSU, 2=MUL, 3=BR.
  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  fu;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   credit [4];
  logic [46:0]     last_disp;

  entry_t          head;
  logic            head_valid, fu_onehot, push, pop, illegal, stall;
  logic [3:0]      credit_nz, credit_full, disp_vec, free_vec;

  assign free_vec = {br_free_i, mul_free_i, lsu_free_i, alu_free_i};

  // Head decode: one-hot FU with a credit dispatches, bad encodings are dropped, flush suppresses both.
  always_comb begin
    head        = mem[rd_ptr];
    head_valid  = (count != '0);
    fu_onehot   = (head.fu != 4'd0) && ((head.fu & (head.fu - 4'd1)) == 4'd0);
    credit_nz   = 4'd0;
    credit_full = 4'd0;
    for (int i = 0; i < 4; i++) begin
      credit_nz[i]   = (credit[i] != '0);
      credit_full[i] = (credit[i] == CW'(RS_DEPTH));
    end
    disp_vec = (head_valid && fu_onehot && !flush_i) ? (head.fu & credit_nz) : 4'd0;
    illegal  = head_valid && !fu_onehot && !flush_i;
    stall    = head_valid && fu_onehot && ((head.fu & credit_nz) == 4'd0);
    pop      = (disp_vec != 4'd0) || illegal;
    push     = inst_valid_i && inst_ready_o && !flush_i;
  end

  assign inst_ready_o = (count != (AW+1)'(DEPTH));
  assign alu_valid_o  = disp_vec[0];
  assign lsu_valid_o  = disp_vec[1];
  assign mul_valid_o  = disp_vec[2];
  assign br_valid_o   = disp_vec[3];
  assign illegal_o    = illegal;

  // The head is shown while present; once empty the last shown entry is held.
  assign {disp_inst_o, disp_rs1_o, disp_rs2_o, disp_rd_o} =
      head_valid ? {head.inst, head.rs1, head.rs2, head.rd} : last_disp;

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= '{inst: inst_i, rs1: rs1_addr_i, rs2: rs2_addr_i, rd: rd_addr_i,
                       fu: {br_i, mul_i, lsu_i, alu_i}};
  end

  // FIFO pointers and occupancy; flush empties by snapping the read pointer to the write pointer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Remember the most recently shown head so the disp outputs hold across an empty FIFO.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)        last_disp <= '0;
    else if (head_valid) last_disp <= {head.inst, head.rs1, head.rs2, head.rd};
  end

  // Per-FU credits: dispatch consumes, free returns, a free at full credit saturates and flags an error.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 4; i++) credit[i] <= CW'(RS_DEPTH);
      credit_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (disp_vec[i] && !free_vec[i])
          credit[i] <= credit[i] - 1'b1;
        else if (free_vec[i] && !disp_vec[i] && !credit_full[i])
          credit[i] <= credit[i] + 1'b1;
      end
      if ((free_vec & ~disp_vec & credit_full) != 4'd0)
        credit_err_o <= 1'b1;
    end
  end

`ifdef DISPATCH_STATS_EN
  // Free-running performance counters; only reset clears them.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_o <= '0;
      disp_cnt_o  <= '0;
    end else begin
      if (stall)             stall_cnt_o <= stall_cnt_o + 32'd1;
      if (disp_vec != 4'd0)  disp_cnt_o  <= disp_cnt_o + 32'd1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb/tb_dispatch_scheduler.sv - randomized and directed self-checking bench for dispatch_scheduler
module tb_dispatch_scheduler;

  localparam int DEPTH = 4;
  localparam int RS    = 4;

  logic        clk_i, reset_i, flush;
  logic        in_valid;
  logic [3:0]  in_fu, in_free;
  logic [31:0] in_inst;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        inst_ready_o, alu_valid_o, lsu_valid_o, mul_valid_o, br_valid_o;
  logic        illegal_o, credit_err_o;
  logic [31:0] disp_inst_o;
  logic [4:0]  disp_rs1_o, disp_rs2_o, disp_rd_o;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_cnt_o, disp_cnt_o;
`endif

  dispatch_scheduler #(.DEPTH(DEPTH), .RS_DEPTH(RS), .CW(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush),
    .inst_valid_i(in_valid), .inst_ready_o(inst_ready_o), .inst_i(in_inst),
    .alu_i(in_fu[0]), .lsu_i(in_fu[1]), .mul_i(in_fu[2]), .br_i(in_fu[3]),
    .rs1_addr_i(in_rs1), .rs2_addr_i(in_rs2), .rd_addr_i(in_rd),
    .alu_valid_o(alu_valid_o), .lsu_valid_o(lsu_valid_o),
    .mul_valid_o(mul_valid_o), .br_valid_o(br_valid_o),
    .disp_inst_o(disp_inst_o), .disp_rs1_o(disp_rs1_o),
    .disp_rs2_o(disp_rs2_o), .disp_rd_o(disp_rd_o),
    .alu_free_i(in_free[0]), .lsu_free_i(in_free[1]),
    .mul_free_i(in_free[2]), .br_free_i(in_free[3]),
    .illegal_o(illegal_o), .credit_err_o(credit_err_o)
`ifdef DISPATCH_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .disp_cnt_o(disp_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [6:0]  obs_ctl;
  logic [46:0] obs_disp;
  assign obs_ctl  = {alu_valid_o, lsu_valid_o, mul_valid_o, br_valid_o, illegal_o, inst_ready_o, credit_err_o};
  assign obs_disp = {disp_inst_o, disp_rs1_o, disp_rs2_o, disp_rd_o};

  // Reference model: a queue of pending instructions plus an integer credit per FU.
  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  fu;
  } ent_t;

  ent_t        mq[$];
  int          cr[4];
  bit          m_err;
  logic [46:0] m_last;
  logic [3:0]  exp_v;
  bit          exp_il;
  logic [6:0]  exp_ctl;
  logic [46:0] exp_disp;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) cr[i] = RS;
    m_err  = 0;
    m_last = '0;
  endtask

  task automatic model_eval();
    exp_v  = 4'd0;
    exp_il = 0;
    if (mq.size() > 0) begin
      if ($countones(mq[0].fu) == 1) begin
        for (int i = 0; i < 4; i++)
          if (mq[0].fu[i] && cr[i] > 0 && !flush) exp_v[i] = 1'b1;
      end else if (!flush) begin
        exp_il = 1;
      end
      exp_disp = {mq[0].inst, mq[0].rs1, mq[0].rs2, mq[0].rd};
    end else begin
      exp_disp = m_last;
    end
    exp_ctl = {exp_v[0], exp_v[1], exp_v[2], exp_v[3], exp_il, (mq.size() < DEPTH), m_err};
  endtask

  task automatic model_adv();
    bit   rdy;
    ent_t e;
    rdy = (mq.size() < DEPTH);
    if (mq.size() > 0) m_last = {mq[0].inst, mq[0].rs1, mq[0].rs2, mq[0].rd};
    for (int i = 0; i < 4; i++) begin
      if (exp_v[i] && !in_free[i]) cr[i]--;
      else if (in_free[i] && !exp_v[i]) begin
        if (cr[i] == RS) m_err = 1;
        else cr[i]++;
      end
    end
    if (exp_v != 4'd0 || exp_il) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (in_valid && rdy) begin
      e.inst = in_inst; e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.fu = in_fu;
      mq.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_fu = 4'd0; in_inst = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_free = 4'd0; flush = 0;
  endtask

  task automatic push(input logic [3:0] fu, input logic [31:0] inst,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    in_valid = 1; in_fu = fu; in_inst = inst; in_rs1 = a; in_rs2 = b; in_rd = d;
  endtask

  task automatic sample();
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_adv();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    checks++; if (obs_ctl !== 7'b0000010) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", obs_ctl, 7'b0000010); end
    checks++; if (obs_disp !== 47'd0) begin errors++; $display("FAIL reset_disp got=%h exp=0", obs_disp); end
    push(4'b0001, 32'h1234_5678, 5'd1, 5'd2, 5'd3);
    advance();
    idle();
    sample();
    checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL reset_pre_strobe got=%b exp=1", alu_valid_o); end
    reset_i = 0;
    #1;
    checks++; if (obs_ctl[6:3] !== 4'd0 || credit_err_o !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0000", obs_ctl[6:3]); end
    checks++; if (obs_disp !== 47'd0) begin errors++; $display("FAIL reset_abort_disp got=%h exp=0", obs_disp); end
    do_reset();
  endtask

  task automatic test_single_alu();
    int strobes = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) push(4'b0001, 32'h00B5_0533, 5'd10, 5'd11, 5'd10);
      if (c >= 2 && c <= 5) push(4'b0001, 32'hA000_0000 + c, 5'd1, 5'd2, 5'd3);
      sample();
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL alu_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL alu_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      if (c == 0) begin
        checks++; if (inst_ready_o !== 1'b1 || alu_valid_o !== 1'b0) begin errors++; $display("FAIL alu_c0 got=%b%b exp=10", inst_ready_o, alu_valid_o); end
      end
      if (c == 1) begin
        checks++; if (alu_valid_o !== 1'b1 || disp_rd_o !== 5'd10 || disp_inst_o !== 32'h00B5_0533) begin
          errors++; $display("FAIL alu_c1 got=%b rd=%0d exp=1 rd=10", alu_valid_o, disp_rd_o); end
      end
      if (c >= 2 && alu_valid_o) strobes++;
      advance();
    end
    checks++; if (strobes !== 3) begin errors++; $display("FAIL alu_credit3 got=%0d exp=3", strobes); end
  endtask

  task automatic test_mul_stall();
    int strobes = 0;
    bit saw_full = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c < 8) push(4'b0100, c, 5'd4, 5'd5, 5'd6);
      if (c == 11) in_free = 4'b0100;
      sample();
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL mul_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL mul_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      if (c <= 11 && mul_valid_o) strobes++;
      if (c < 11 && !inst_ready_o) saw_full = 1;
      if (c == 12) begin
        checks++; if (mul_valid_o !== 1'b1 || disp_inst_o !== 32'd4) begin
          errors++; $display("FAIL mul_fifth got=%b inst=%0d exp=1 inst=4", mul_valid_o, disp_inst_o); end
      end
      advance();
    end
    checks++; if (strobes !== 4) begin errors++; $display("FAIL mul_strobes got=%0d exp=4", strobes); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL mul_full got=%b exp=1", saw_full); end
  endtask

  task automatic test_in_order();
    int lsu_early = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle();
      if (c < 5) push(4'b0100, 100 + c, 5'd1, 5'd1, 5'd1);
      if (c == 5) push(4'b0010, 200, 5'd2, 5'd2, 5'd2);
      if (c == 12) in_free = 4'b0100;
      sample();
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL order_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL order_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      if (c <= 13 && lsu_valid_o) lsu_early++;
      if (c == 13) begin
        checks++; if (mul_valid_o !== 1'b1 || disp_inst_o !== 32'd104) begin errors++; $display("FAIL order_mul got=%b inst=%0d exp=1 inst=104", mul_valid_o, disp_inst_o); end
      end
      if (c == 14) begin
        checks++; if (lsu_valid_o !== 1'b1 || disp_inst_o !== 32'd200) begin errors++; $display("FAIL order_lsu got=%b inst=%0d exp=1 inst=200", lsu_valid_o, disp_inst_o); end
      end
      advance();
    end
    checks++; if (lsu_early !== 0) begin errors++; $display("FAIL order_lsu_early got=%0d exp=0", lsu_early); end
  endtask

  task automatic test_illegal();
    int ill = 0, ill_strobe = 0, good = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) push(4'b0000, 1, 5'd0, 5'd0, 5'd0);
      if (c == 1) push(4'b1001, 2, 5'd0, 5'd0, 5'd0);
      if (c == 2) push(4'b0001, 3, 5'd0, 5'd0, 5'd0);
      if (c == 3) push(4'b1000, 4, 5'd0, 5'd0, 5'd0);
      sample();
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL ill_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL ill_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      if (illegal_o) ill++;
      if (c <= 2 && obs_ctl[6:3] != 4'd0) ill_strobe++;
      if (alu_valid_o || br_valid_o) good++;
      advance();
    end
    checks++; if (ill !== 2) begin errors++; $display("FAIL ill_pulses got=%0d exp=2", ill); end
    checks++; if (ill_strobe !== 0) begin errors++; $display("FAIL ill_strobes got=%0d exp=0", ill_strobe); end
    checks++; if (good !== 2) begin errors++; $display("FAIL ill_followers got=%0d exp=2", good); end
  endtask

  task automatic test_flush_wrap();
    logic [31:0] seen[$];
    int mul_after = 0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      idle();
      if (c < 8) push(4'b0100, 32'hC000 + c, 5'd3, 5'd3, 5'd3);
      if (c == 8) begin flush = 1; push(4'b0001, 999, 5'd9, 5'd9, 5'd9); end
      if (c >= 9 && c < 9 + 3 * DEPTH) push(4'b0001, 500 + c - 9, 5'(c), 5'(c + 1), 5'(c + 2));
      if (c == 24) push(4'b0100, 777, 5'd7, 5'd7, 5'd7);
      sample();
      in_free[0] = exp_v[0];
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL flush_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL flush_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      if (c == 8) begin
        checks++; if (inst_ready_o !== 1'b0) begin errors++; $display("FAIL flush_full got=%b exp=0", inst_ready_o); end
      end
      if (c == 9) begin
        checks++; if (inst_ready_o !== 1'b1 || obs_ctl[6:3] !== 4'd0) begin errors++; $display("FAIL flush_empty got=%b %b exp=1 0000", inst_ready_o, obs_ctl[6:3]); end
      end
      if (alu_valid_o) seen.push_back(disp_inst_o);
      if (c >= 24 && mul_valid_o) mul_after++;
      advance();
    end
    checks++; if (seen.size() !== 3 * DEPTH) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", seen.size(), 3 * DEPTH); end
    for (int k = 0; k < seen.size() && k < 3 * DEPTH; k++) begin
      checks++; if (seen[k] !== 32'(500 + k)) begin errors++; $display("FAIL wrap_order k=%0d got=%0d exp=%0d", k, seen[k], 500 + k); end
    end
    checks++; if (mul_after !== 0) begin errors++; $display("FAIL flush_credit got=%0d exp=0", mul_after); end
  endtask

  task automatic test_credit_err();
    int strobes = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c == 0) in_free = 4'b1000;
      if (c == 1) push(4'b0001, 1, 5'd1, 5'd1, 5'd1);
      if (c == 2) in_free = 4'b0001;
      if (c >= 3 && c <= 7) push(4'b0001, 10 + c, 5'd1, 5'd1, 5'd1);
      sample();
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL cerr_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL cerr_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      if (c == 1) begin
        checks++; if (credit_err_o !== 1'b1) begin errors++; $display("FAIL cerr_set got=%b exp=1", credit_err_o); end
      end
      if (c == 2) begin
        checks++; if (alu_valid_o !== 1'b1) begin errors++; $display("FAIL cerr_alu got=%b exp=1", alu_valid_o); end
      end
      if (c >= 3 && alu_valid_o) strobes++;
      advance();
    end
    checks++; if (strobes !== 4) begin errors++; $display("FAIL cerr_alu_credit got=%0d exp=4", strobes); end
    checks++; if (credit_err_o !== 1'b1) begin errors++; $display("FAIL cerr_sticky got=%b exp=1", credit_err_o); end
    do_reset();
    #1;
    checks++; if (credit_err_o !== 1'b0) begin errors++; $display("FAIL cerr_clear got=%b exp=0", credit_err_o); end
  endtask

  task automatic test_random();
    logic [3:0] f;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        f = ($urandom_range(0, 9) < 8) ? (4'd1 << $urandom_range(0, 3)) : 4'($urandom);
        push(f, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      end
      for (int i = 0; i < 4; i++) in_free[i] = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 29) == 0);
      sample();
      checks++; if (obs_ctl !== exp_ctl) begin errors++; $display("FAIL rand_ctl c=%0d got=%b exp=%b", c, obs_ctl, exp_ctl); end
      checks++; if (obs_disp !== exp_disp) begin errors++; $display("FAIL rand_disp c=%0d got=%h exp=%h", c, obs_disp, exp_disp); end
      advance();
    end
  endtask

  initial begin
    idle();
    reset_i = 0;
    model_reset();
    test_reset();
    test_single_alu();
    test_mul_stall();
    test_in_order();
    test_illegal();
    test_flush_wrap();
    test_credit_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
